// File: rtl/psa_arbiter_if.sv
// Bus bundle between the PSA arbiter, its two requesters, the shared PSA and the stats taps.
// master = arbiter side, slave = requesters/PSA/environment side.
interface psa_arbiter_if #(
    parameter int unsigned DATA_W = 16
);
    logic              ex_own;

    logic              req0_valid;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req0_ready;

    logic              req1_valid;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              req1_ready;

    logic [DATA_W-1:0] psa_a;
    logic [DATA_W-1:0] psa_b;
    logic              psa_sel;
    logic [DATA_W-1:0] psa_sum;
    logic              psa_error;

    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp_sum;
    logic              rsp_error;

    logic [15:0]       stat_gnt0;
    logic [15:0]       stat_gnt1;
    logic [15:0]       stat_sat;

    modport master (
        input  ex_own,
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  psa_sum, psa_error,
        output req0_ready, req1_ready,
        output psa_a, psa_b, psa_sel,
        output rsp0_valid, rsp1_valid, rsp_sum, rsp_error,
        output stat_gnt0, stat_gnt1, stat_sat
    );

    modport slave (
        output ex_own,
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output psa_sum, psa_error,
        input  req0_ready, req1_ready,
        input  psa_a, psa_b, psa_sel,
        input  rsp0_valid, rsp1_valid, rsp_sum, rsp_error,
        input  stat_gnt0, stat_gnt1, stat_sat
    );
endinterface

// File: rtl/psa_arbiter.sv
// Two-requester arbiter/issue sequencer for the shared 4x4-bit saturating PSA, 2-cycle response.
// Optional grant/saturation counters are built when PSA_ARB_STATS_EN is defined.
module psa_arbiter #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    psa_arbiter_if.master bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        FORCE1 = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               gnt0_c, gnt1_c;

    logic               s1_valid_q, s1_valid_d;
    logic               s1_owner_q, s1_owner_d;
    logic [DATA_W-1:0]  psa_a_q, psa_a_d;
    logic [DATA_W-1:0]  psa_b_q, psa_b_d;

    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0]  rsp_sum_q, rsp_sum_d;
    logic               rsp_error_q, rsp_error_d;

    // FSM state and starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Grant selection, starvation tracking and next state
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        gnt0_c   = 1'b0;
        gnt1_c   = 1'b0;

        if (!bus.ex_own) begin
            if (state_q == FORCE1 && bus.req1_valid) begin
                gnt1_c = 1'b1;
            end else if (bus.req0_valid) begin
                gnt0_c = 1'b1;
            end else if (bus.req1_valid) begin
                gnt1_c = 1'b1;
            end
        end

        if (gnt1_c || !bus.req1_valid) begin
            starve_d = '0;
        end else if (gnt0_c && starve_q != '1) begin
            starve_d = starve_q + CNT_W'(1);
        end

        // Look ahead on the next count so req1 is forced on the very next cycle
        case (state_q)
            ARB: begin
                if (starve_d >= CNT_W'(STARVE_LIMIT)) begin
                    state_d = FORCE1;
                end
            end
            FORCE1: begin
                if (gnt1_c || !bus.req1_valid) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Stage-1 operand capture and stage-2 response capture
    always_comb begin
        s1_valid_d   = 1'b0;
        s1_owner_d   = s1_owner_q;
        psa_a_d      = psa_a_q;
        psa_b_d      = psa_b_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp_sum_d    = rsp_sum_q;
        rsp_error_d  = rsp_error_q;

        if (gnt0_c || gnt1_c) begin
            s1_valid_d = 1'b1;
            s1_owner_d = gnt1_c;
            psa_a_d    = gnt1_c ? bus.req1_a : bus.req0_a;
            psa_b_d    = gnt1_c ? bus.req1_b : bus.req0_b;
        end

        if (s1_valid_q) begin
            rsp0_valid_d = !s1_owner_q;
            rsp1_valid_d = s1_owner_q;
            rsp_sum_d    = bus.psa_sum;
            rsp_error_d  = bus.psa_error;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_owner_q   <= 1'b0;
            psa_a_q      <= '0;
            psa_b_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_owner_q   <= s1_owner_d;
            psa_a_q      <= psa_a_d;
            psa_b_q      <= psa_b_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    assign bus.req0_ready = gnt0_c;
    assign bus.req1_ready = gnt1_c;
    assign bus.psa_a      = psa_a_q;
    assign bus.psa_b      = psa_b_q;
    assign bus.psa_sel    = s1_valid_q;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_sum    = rsp_sum_q;
    assign bus.rsp_error  = rsp_error_q;

`ifdef PSA_ARB_STATS_EN
    logic [STAT_W-1:0] stat_gnt0_q, stat_gnt1_q, stat_sat_q;

    // Saturating event counters; saturation is counted as the response is captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_gnt0_q <= '0;
            stat_gnt1_q <= '0;
            stat_sat_q  <= '0;
        end else begin
            if (gnt0_c && stat_gnt0_q != '1) begin
                stat_gnt0_q <= stat_gnt0_q + STAT_W'(1);
            end
            if (gnt1_c && stat_gnt1_q != '1) begin
                stat_gnt1_q <= stat_gnt1_q + STAT_W'(1);
            end
            if (s1_valid_q && bus.psa_error && stat_sat_q != '1) begin
                stat_sat_q <= stat_sat_q + STAT_W'(1);
            end
        end
    end

    assign bus.stat_gnt0 = stat_gnt0_q;
    assign bus.stat_gnt1 = stat_gnt1_q;
    assign bus.stat_sat  = stat_sat_q;
`else
    assign bus.stat_gnt0 = STAT_W'(0);
    assign bus.stat_gnt1 = STAT_W'(0);
    assign bus.stat_sat  = STAT_W'(0);
`endif

endmodule

// File: tb/tb_psa_arbiter.sv
// Directed bench for psa_arbiter with a behavioural 4x4-bit signed saturating PSA.
module tb_psa_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    psa_arbiter_if #(.DATA_W(16)) bus ();

    psa_arbiter #(.DATA_W(16), .STARVE_LIMIT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference PSA: four independent signed 4-bit lanes, clamp to +7 / -8
    always_comb begin
        logic signed [4:0] s;
        logic [15:0]       sum;
        logic              err;
        sum = '0;
        err = 1'b0;
        for (int l = 0; l < 4; l++) begin
            s = 5'($signed(bus.psa_a[4*l +: 4])) + 5'($signed(bus.psa_b[4*l +: 4]));
            if (s > 5'sd7) begin
                sum[4*l +: 4] = 4'h7;
                err = 1'b1;
            end else if (s < -5'sd8) begin
                sum[4*l +: 4] = 4'h8;
                err = 1'b1;
            end else begin
                sum[4*l +: 4] = s[3:0];
            end
        end
        bus.psa_sum   = sum;
        bus.psa_error = err;
    end

    logic ex_own_prev;
    always @(posedge clk) ex_own_prev <= bus.ex_own;
    always @(negedge clk) begin
        if (rst_n && bus.ex_own && !ex_own_prev && bus.psa_sel)
            $error("FAIL ex_own_legal: ex_own rose while psa_sel=1");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    int exp_g0, exp_g1, exp_r0, exp_r1, exp_sum, exp_err;
    int exp_stat_gnt0, exp_stat_gnt1, exp_stat_sat;
    logic [15:0] t6_a [5];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.ex_own     = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_psa_sel", 32'(bus.psa_sel), 0);
        check_eq("rst_psa_a",   32'(bus.psa_a), 0);
        check_eq("rst_rsp0",    32'(bus.rsp0_valid), 0);
        check_eq("rst_rsp1",    32'(bus.rsp1_valid), 0);
        check_eq("rst_rsp_sum", 32'(bus.rsp_sum), 0);
        check_eq("rst_rsp_err", 32'(bus.rsp_error), 0);
        nxt();
        rst_n = 1'b1;

        // req0 only, no saturation
        nxt();
        bus.req0_valid = 1'b1; bus.req0_a = 16'h1234; bus.req0_b = 16'h1111;
        @(negedge clk);
        check_eq("t1_rdy0", 32'(bus.req0_ready), 1);
        check_eq("t1_rdy1", 32'(bus.req1_ready), 0);
        check_eq("t1_sel_c0", 32'(bus.psa_sel), 0);
        nxt();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_sel", 32'(bus.psa_sel), 1);
        check_eq("t1_psa_a", 32'(bus.psa_a), 'h1234);
        check_eq("t1_psa_b", 32'(bus.psa_b), 'h1111);
        check_eq("t1_rsp0_early", 32'(bus.rsp0_valid), 0);
        nxt();
        @(negedge clk);
        check_eq("t1_rsp0", 32'(bus.rsp0_valid), 1);
        check_eq("t1_rsp1", 32'(bus.rsp1_valid), 0);
        check_eq("t1_sum", 32'(bus.rsp_sum), 'h2345);
        check_eq("t1_err", 32'(bus.rsp_error), 0);
        nxt();
        @(negedge clk);
        check_eq("t1_rsp0_pulse", 32'(bus.rsp0_valid), 0);
        check_eq("t1_sum_hold", 32'(bus.rsp_sum), 'h2345);
        check_eq("t1_sel_idle", 32'(bus.psa_sel), 0);
        check_eq("t1_psa_a_hold", 32'(bus.psa_a), 'h1234);

        // req1 only, every lane saturates positive
        nxt();
        bus.req1_valid = 1'b1; bus.req1_a = 16'h7777; bus.req1_b = 16'h1111;
        @(negedge clk);
        check_eq("t2_rdy1", 32'(bus.req1_ready), 1);
        check_eq("t2_rdy0", 32'(bus.req0_ready), 0);
        nxt();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check_eq("t2_sel", 32'(bus.psa_sel), 1);
        nxt();
        @(negedge clk);
        check_eq("t2_rsp1", 32'(bus.rsp1_valid), 1);
        check_eq("t2_rsp0", 32'(bus.rsp0_valid), 0);
        check_eq("t2_sum", 32'(bus.rsp_sum), 'h7777);
        check_eq("t2_err", 32'(bus.rsp_error), 1);

        // Both requesting continuously: pattern 0,0,0,1 repeating
        bus.req0_a = 16'h0101; bus.req0_b = 16'h0101;
        bus.req1_a = 16'h0003; bus.req1_b = 16'h000F;
        for (int i = 0; i < 14; i++) begin
            nxt();
            bus.req0_valid = (i < 12);
            bus.req1_valid = (i < 12);
            @(negedge clk);
            exp_g1 = (i < 12 && i % 4 == 3) ? 1 : 0;
            exp_g0 = (i < 12 && i % 4 != 3) ? 1 : 0;
            exp_r1 = (i >= 2 && (i - 2) % 4 == 3) ? 1 : 0;
            exp_r0 = (i >= 2 && (i - 2) % 4 != 3) ? 1 : 0;
            check_eq($sformatf("t3_rdy0_%0d", i), 32'(bus.req0_ready), exp_g0);
            check_eq($sformatf("t3_rdy1_%0d", i), 32'(bus.req1_ready), exp_g1);
            check_eq($sformatf("t3_rsp0_%0d", i), 32'(bus.rsp0_valid), exp_r0);
            check_eq($sformatf("t3_rsp1_%0d", i), 32'(bus.rsp1_valid), exp_r1);
            if (i >= 2)
                check_eq($sformatf("t3_sum_%0d", i), 32'(bus.rsp_sum), (exp_r1 == 1) ? 'h0002 : 'h0202);
        end

        // ex_own blocks both requesters; req0 wins once released
        nxt();
        bus.ex_own = 1'b1; bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nxt();
            @(negedge clk);
            check_eq($sformatf("t4_rdy0_%0d", i), 32'(bus.req0_ready), 0);
            check_eq($sformatf("t4_rdy1_%0d", i), 32'(bus.req1_ready), 0);
            check_eq($sformatf("t4_sel_%0d", i), 32'(bus.psa_sel), 0);
        end
        nxt();
        bus.ex_own = 1'b0;
        @(negedge clk);
        check_eq("t4_rdy0_rel", 32'(bus.req0_ready), 1);
        check_eq("t4_rdy1_rel", 32'(bus.req1_ready), 0);
        nxt();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_psa_a", 32'(bus.psa_a), 'h0101);
        nxt();
        @(negedge clk);
        check_eq("t4_rsp0", 32'(bus.rsp0_valid), 1);
        check_eq("t4_sum", 32'(bus.rsp_sum), 'h0202);

        // Reset right after a grant, with the FSM about to force req1
        for (int i = 0; i < 3; i++) begin
            nxt();
            bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
            @(negedge clk);
            check_eq($sformatf("t5_pre_rdy0_%0d", i), 32'(bus.req0_ready), 1);
        end
        nxt();
        rst_n = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        check_eq("t5_sel", 32'(bus.psa_sel), 0);
        check_eq("t5_psa_a", 32'(bus.psa_a), 0);
        check_eq("t5_rsp_sum", 32'(bus.rsp_sum), 0);
        check_eq("t5_rsp0", 32'(bus.rsp0_valid), 0);
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t5_rsp0_post", 32'(bus.rsp0_valid), 0);
        check_eq("t5_rsp1_post", 32'(bus.rsp1_valid), 0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
            @(negedge clk);
            exp_g1 = (i == 3) ? 1 : 0;
            check_eq($sformatf("t5_rdy1_%0d", i), 32'(bus.req1_ready), exp_g1);
            check_eq($sformatf("t5_rdy0_%0d", i), 32'(bus.req0_ready), 1 - exp_g1);
        end

        // Five req0 ops, two saturating, from a fresh reset
        nxt();
        rst_n = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        nxt();
        rst_n = 1'b1;
        t6_a[0] = 16'h7777; t6_a[1] = 16'h1234; t6_a[2] = 16'h7777;
        t6_a[3] = 16'h1234; t6_a[4] = 16'h1234;
        bus.req0_b = 16'h1111;
        for (int i = 0; i < 7; i++) begin
            nxt();
            bus.req0_valid = (i < 5);
            if (i < 5) bus.req0_a = t6_a[i];
            @(negedge clk);
            if (i >= 2) begin
                exp_sum = (t6_a[i-2] == 16'h7777) ? 'h7777 : 'h2345;
                exp_err = (t6_a[i-2] == 16'h7777) ? 1 : 0;
                check_eq($sformatf("t6_rsp0_%0d", i), 32'(bus.rsp0_valid), 1);
                check_eq($sformatf("t6_sum_%0d", i), 32'(bus.rsp_sum), exp_sum);
                check_eq($sformatf("t6_err_%0d", i), 32'(bus.rsp_error), exp_err);
            end
        end
`ifdef PSA_ARB_STATS_EN
        exp_stat_gnt0 = 5; exp_stat_gnt1 = 0; exp_stat_sat = 2;
`else
        exp_stat_gnt0 = 0; exp_stat_gnt1 = 0; exp_stat_sat = 0;
`endif
        check_eq("t6_stat_gnt0", 32'(bus.stat_gnt0), exp_stat_gnt0);
        check_eq("t6_stat_gnt1", 32'(bus.stat_gnt1), exp_stat_gnt1);
        check_eq("t6_stat_sat",  32'(bus.stat_sat),  exp_stat_sat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/psa_arbiter.md
Name: psa_arbiter

Overview:
Two-requester arbiter and issue sequencer for the shared 16-bit parallel sub-word adder (PSA, 4 x 4-bit saturating lanes).
- Requester 0 is the EX-stage PADDSB path; requester 1 is the multi-cycle reduction/RED helper.
- The block grants one requester per cycle and registers the selected operands onto the PSA inputs.
- It captures the PSA sum/error and returns them to the owner with a fixed 2-cycle latency.
- It yields the PSA entirely while the pipeline asserts ex_own.

Parameters:
DATA_W, 16, operand/result width; must be 16 (PSA is fixed at 4 x 4-bit lanes)
STARVE_LIMIT, 3, max consecutive req0 grants while req1 is waiting before req1 is forced (range 1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_own  in  1  pipeline holds PSA this cycle; arbiter must not issue
req0_valid  in  1  requester 0 has an operation
req0_a  in  16  requester 0 operand A
req0_b  in  16  requester 0 operand B
req0_ready  out  1  requester 0 accepted this cycle
req1_valid  in  1  requester 1 has an operation
req1_a  in  16  requester 1 operand A
req1_b  in  16  requester 1 operand B
req1_ready  out  1  requester 1 accepted this cycle
psa_a  out  16  registered operand A to PSA
psa_b  out  16  registered operand B to PSA
psa_sel  out  1  arbiter drives PSA this cycle (PSA mux select)
psa_sum  in  16  PSA combinational sum
psa_error  in  1  PSA saturation flag
rsp0_valid  out  1  one-cycle pulse: result for requester 0
rsp1_valid  out  1  one-cycle pulse: result for requester 1
rsp_sum  out  16  registered result
rsp_error  out  1  registered saturation flag
stat_gnt0  out  16  grant count, requester 0 (optional feature)
stat_gnt1  out  16  grant count, requester 1 (optional feature)
stat_sat  out  16  saturated-result count (optional feature)

Behaviour:
- Reset (async, rst_n=0): all outputs 0, stage-1 valid 0, starvation counter 0, FSM = ARB.
- FSM states:
  - ARB: normal priority; req0 wins.
  - FORCE1: req1 wins if valid.
  - Transitions:
    - ARB->FORCE1 when the starvation counter reaches STARVE_LIMIT.
    - FORCE1->ARB after one req1 grant.
    - FORCE1->ARB if req1_valid drops before it is granted.
- Starvation counter:
  - Increments on a req0 grant while req1_valid=1.
  - Clears on any req1 grant, or on any cycle with req1_valid=0.
- Grants:
  - req*_ready are combinational.
  - At most one is high per cycle.
  - Both are 0 whenever ex_own=1.
  - A transaction occurs on valid&ready.
  - Requesters hold operands stable until ready.
- Pipeline:
  - Cycle N: grant.
  - Cycle N+1: psa_a/psa_b hold the captured operands; psa_sel=1; owner tag registered.
  - Cycle N+2: rsp_sum/rsp_error = PSA outputs sampled at the end of N+1; rspX_valid=1 for the owner only.
  - Throughput is 1 op/cycle.
- psa_sel=0 on every cycle with no stage-1 op. psa_a/psa_b hold their last value (no toggling).
- ex_own rising while stage-1 is valid is illegal; the pipeline guarantees ex_own only asserts with psa_sel=0. The bench asserts this.
- No response back-pressure. rsp_sum/rsp_error hold until the next response. rsp*_valid are single-cycle pulses.
- Reset mid-operation discards in-flight ops; no response is issued.

Optional Feature:
Macro PSA_ARB_STATS_EN.
- Defined:
  - stat_gnt0/stat_gnt1 increment on each grant.
  - stat_sat increments on each response with rsp_error=1.
  - All three saturate at 0xFFFF and clear on reset.
- Undefined: the counters are not built and the stat_* ports are tied to 0.

Test Plan:
- req0 only, a=0x1234, b=0x1111 at cycle 0 -> req0_ready cycle 0; psa_sel cycle 1; rsp0_valid cycle 2 with rsp_sum=0x2345, rsp_error=0.
- req1 only, a=0x7777, b=0x1111 -> rsp1_valid 2 cycles later, rsp_sum=0x7777, rsp_error=1 (positive lane saturation).
- Both valid continuously, STARVE_LIMIT=3 -> grant pattern 0,0,0,1,0,0,0,1,...; each response pulses the correct rspX_valid.
- ex_own=1 for 4 cycles with both valid -> both ready=0 and psa_sel=0 throughout; req0 is granted on the first cycle after ex_own drops.
- rst_n pulsed low the cycle after a grant -> no rsp*_valid pulses; all outputs 0; FSM=ARB.
- With PSA_ARB_STATS_EN, 5 req0 ops of which 2 saturate -> stat_gnt0=5, stat_gnt1=0, stat_sat=2.
